// File: rtl/csr_regfile_pkg.sv
// Shared CSR address map, mstatus field layout and write-masking helpers.
package csr_regfile_pkg;

  localparam int unsigned CNT_W = 64;

  // Machine-mode CSRs
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // User-level read-only counter aliases
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // mstatus fields
  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam logic [31:0] MSTATUS_RST  = 32'h0000_1800;  // MPP hardwired to M-mode
  localparam logic [31:0] MSTATUS_WMSK = 32'h0000_0088;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
  } csr_wr_t;

  // True for addresses whose writes are actually stored.
  function automatic logic csr_writable(input logic [11:0] addr);
    logic ok;
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: ok = 1'b1;
      default:                                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Value that a write of data to addr will store (and read back as).
  function automatic logic [31:0] csr_wmask(input logic [11:0] addr, input logic [31:0] data);
    logic [31:0] val;
    case (addr)
      CSR_MSTATUS:         val = MSTATUS_RST | (data & MSTATUS_WMSK);
      CSR_MTVEC, CSR_MEPC: val = {data[31:2], 2'b00};
      default:             val = data;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit wrapping counter with independently writable 32-bit halves.
module csr_counter64
  import csr_regfile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             we_lo,
  input  logic             we_hi,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q, value_d;

  // Any half write replaces that half and suppresses the increment this cycle.
  always_comb begin
    value_d = value_q;
    if (we_lo || we_hi) begin
      if (we_lo) value_d[31:0]       = wdata[31:0];
      if (we_hi) value_d[CNT_W-1:32] = wdata[CNT_W-1:32];
    end else if (inc) begin
      value_d = value_q + 64'd1;
    end
  end

  // Counter state, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file with two write ports (pipeline and trap controller).
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] HART_ID   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_retired,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  input  logic        ex_csr_we,
  input  logic [11:0] ex_csr_waddr,
  input  logic [31:0] ex_csr_wdata,
  input  logic        clint_csr_we,
  input  logic [11:0] clint_csr_waddr,
  input  logic [31:0] clint_csr_wdata,
  output logic [31:0] csr_mtvec,
  output logic [31:0] csr_mepc,
  output logic [31:0] csr_mstatus,
  output logic        global_int_en
);

  csr_wr_t clint_wr, ex_wr;

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle, minstret;

  function automatic logic wr_hit(input csr_wr_t a, input csr_wr_t b, input logic [11:0] addr);
    return (a.we && (a.addr == addr)) || (b.we && (b.addr == addr));
  endfunction

  // Clint data wins whenever it targets addr.
  function automatic logic [31:0] wr_data(input csr_wr_t clint, input csr_wr_t ex,
                                          input logic [11:0] addr);
    return (clint.we && (clint.addr == addr)) ? clint.data : ex.data;
  endfunction

  // Qualify both ports: drop writes to read-only/unimplemented CSRs, and the ex
  // write when the clint targets the same address.
  always_comb begin
    clint_wr.we   = clint_csr_we && csr_writable(clint_csr_waddr);
    clint_wr.addr = clint_csr_waddr;
    clint_wr.data = csr_wmask(clint_csr_waddr, clint_csr_wdata);
    ex_wr.we      = ex_csr_we && csr_writable(ex_csr_waddr) &&
                    !(clint_wr.we && (clint_csr_waddr == ex_csr_waddr));
    ex_wr.addr    = ex_csr_waddr;
    ex_wr.data    = csr_wmask(ex_csr_waddr, ex_csr_wdata);
  end

  // Next-state for the plain registers.
  always_comb begin
    mstatus_d  = wr_hit(clint_wr, ex_wr, CSR_MSTATUS)  ?
                 wr_data(clint_wr, ex_wr, CSR_MSTATUS)  : mstatus_q;
    mie_d      = wr_hit(clint_wr, ex_wr, CSR_MIE)      ?
                 wr_data(clint_wr, ex_wr, CSR_MIE)      : mie_q;
    mtvec_d    = wr_hit(clint_wr, ex_wr, CSR_MTVEC)    ?
                 wr_data(clint_wr, ex_wr, CSR_MTVEC)    : mtvec_q;
    mscratch_d = wr_hit(clint_wr, ex_wr, CSR_MSCRATCH) ?
                 wr_data(clint_wr, ex_wr, CSR_MSCRATCH) : mscratch_q;
    mepc_d     = wr_hit(clint_wr, ex_wr, CSR_MEPC)     ?
                 wr_data(clint_wr, ex_wr, CSR_MEPC)     : mepc_q;
    mcause_d   = wr_hit(clint_wr, ex_wr, CSR_MCAUSE)   ?
                 wr_data(clint_wr, ex_wr, CSR_MCAUSE)   : mcause_q;
  end

  // Register state, synchronous reset overrides any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= MSTATUS_RST;
      mie_q      <= '0;
      mtvec_q    <= {MTVEC_RST[31:2], 2'b00};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .we_lo (wr_hit(clint_wr, ex_wr, CSR_MCYCLE)),
    .we_hi (wr_hit(clint_wr, ex_wr, CSR_MCYCLEH)),
    .wdata ({wr_data(clint_wr, ex_wr, CSR_MCYCLEH), wr_data(clint_wr, ex_wr, CSR_MCYCLE)}),
    .value (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (inst_retired),
    .we_lo (wr_hit(clint_wr, ex_wr, CSR_MINSTRET)),
    .we_hi (wr_hit(clint_wr, ex_wr, CSR_MINSTRETH)),
    .wdata ({wr_data(clint_wr, ex_wr, CSR_MINSTRETH), wr_data(clint_wr, ex_wr, CSR_MINSTRET)}),
    .value (minstret)
  );

  // Read mux: forward in-flight write data (clint first), else stored contents.
  always_comb begin
    csr_rdata = 32'h0;
    if (clint_wr.we && (clint_wr.addr == csr_raddr)) begin
      csr_rdata = clint_wr.data;
    end else if (ex_wr.we && (ex_wr.addr == csr_raddr)) begin
      csr_rdata = ex_wr.data;
    end else begin
      case (csr_raddr)
        CSR_MSTATUS:                 csr_rdata = mstatus_q;
        CSR_MIE:                     csr_rdata = mie_q;
        CSR_MTVEC:                   csr_rdata = mtvec_q;
        CSR_MSCRATCH:                csr_rdata = mscratch_q;
        CSR_MEPC:                    csr_rdata = mepc_q;
        CSR_MCAUSE:                  csr_rdata = mcause_q;
        CSR_MCYCLE,   CSR_CYCLE:     csr_rdata = mcycle[31:0];
        CSR_MCYCLEH,  CSR_CYCLEH:    csr_rdata = mcycle[63:32];
        CSR_MINSTRET, CSR_INSTRET:   csr_rdata = minstret[31:0];
        CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = minstret[63:32];
        CSR_MHARTID:                 csr_rdata = HART_ID;
        default:                     csr_rdata = 32'h0;
      endcase
    end
  end

  assign csr_mtvec     = mtvec_q;
  assign csr_mepc      = mepc_q;
  assign csr_mstatus   = mstatus_q;
  assign global_int_en = mstatus_q[MSTATUS_MIE];

endmodule

// File: tb/tb_csr_regfile.sv
// Directed and random stimulus for csr_regfile against a behavioural CSR model.
module tb_csr_regfile;

  localparam logic [31:0] TB_MTVEC_RST = 32'h8000_0003;
  localparam logic [31:0] TB_HART_ID   = 32'h0000_0005;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_retired;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        ex_csr_we;
  logic [11:0] ex_csr_waddr;
  logic [31:0] ex_csr_wdata;
  logic        clint_csr_we;
  logic [11:0] clint_csr_waddr;
  logic [31:0] clint_csr_wdata;
  logic [31:0] csr_mtvec, csr_mepc, csr_mstatus;
  logic        global_int_en;

  always #5 clk = ~clk;

  csr_regfile #(
    .MTVEC_RST (TB_MTVEC_RST),
    .HART_ID   (TB_HART_ID)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_retired    (inst_retired),
    .csr_raddr       (csr_raddr),
    .csr_rdata       (csr_rdata),
    .ex_csr_we       (ex_csr_we),
    .ex_csr_waddr    (ex_csr_waddr),
    .ex_csr_wdata    (ex_csr_wdata),
    .clint_csr_we    (clint_csr_we),
    .clint_csr_waddr (clint_csr_waddr),
    .clint_csr_wdata (clint_csr_wdata),
    .csr_mtvec       (csr_mtvec),
    .csr_mepc        (csr_mepc),
    .csr_mstatus     (csr_mstatus),
    .global_int_en   (global_int_en)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model state
  bit          model_valid = 1'b0;
  bit          m_mie_bit, m_mpie_bit;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_status(input bit mie, input bit mpie);
    return 32'h0000_1800 | (32'(mpie) << 7) | (32'(mie) << 3);
  endfunction

  function automatic bit m_writable(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'hB00, 12'hB80, 12'hB02, 12'hB82};
  endfunction

  // Value a write reads back as.
  function automatic logic [31:0] m_mask(input logic [11:0] a, input logic [31:0] d);
    if (a == 12'h300) return m_status(d[3], d[7]);
    if (a == 12'h305 || a == 12'h341) return d & 32'hFFFF_FFFC;
    return d;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300:          return m_status(m_mie_bit, m_mpie_bit);
      12'h304:          return m_mie;
      12'h305:          return m_mtvec;
      12'h340:          return m_mscratch;
      12'h341:          return m_mepc;
      12'h342:          return m_mcause;
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      12'hF14:          return TB_HART_ID;
      default:          return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_expected_rdata();
    if (clint_csr_we && csr_raddr == clint_csr_waddr && m_writable(csr_raddr))
      return m_mask(csr_raddr, clint_csr_wdata);
    if (ex_csr_we && csr_raddr == ex_csr_waddr && m_writable(csr_raddr))
      return m_mask(csr_raddr, ex_csr_wdata);
    return m_read(csr_raddr);
  endfunction

  bit cyc_written, ins_written;

  task automatic m_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h300: begin m_mie_bit = d[3]; m_mpie_bit = d[7]; end
      12'h304: m_mie = d;
      12'h305: m_mtvec = d & 32'hFFFF_FFFC;
      12'h340: m_mscratch = d;
      12'h341: m_mepc = d & 32'hFFFF_FFFC;
      12'h342: m_mcause = d;
      12'hB00: begin m_cyc[31:0] = d;  cyc_written = 1'b1; end
      12'hB80: begin m_cyc[63:32] = d; cyc_written = 1'b1; end
      12'hB02: begin m_ins[31:0] = d;  ins_written = 1'b1; end
      12'hB82: begin m_ins[63:32] = d; ins_written = 1'b1; end
      default: ;
    endcase
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic m_edge();
    if (rst) begin
      m_mie_bit = 1'b0; m_mpie_bit = 1'b0;
      m_mie = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_mtvec = TB_MTVEC_RST & 32'hFFFF_FFFC;
      m_cyc = 0; m_ins = 0;
      model_valid = 1'b1;
    end else begin
      cyc_written = 1'b0;
      ins_written = 1'b0;
      if (ex_csr_we && !(clint_csr_we && clint_csr_waddr == ex_csr_waddr))
        m_write(ex_csr_waddr, ex_csr_wdata);
      if (clint_csr_we) m_write(clint_csr_waddr, clint_csr_wdata);
      if (!cyc_written) m_cyc = m_cyc + 64'd1;
      if (!ins_written && inst_retired) m_ins = m_ins + 64'd1;
    end
  endtask

  task automatic apply(input logic r, input logic ret, input logic [11:0] ra,
                       input logic ewe, input logic [11:0] ea, input logic [31:0] ed,
                       input logic cwe, input logic [11:0] ca, input logic [31:0] cd);
    rst = r; inst_retired = ret; csr_raddr = ra;
    ex_csr_we = ewe; ex_csr_waddr = ea; ex_csr_wdata = ed;
    clint_csr_we = cwe; clint_csr_waddr = ca; clint_csr_wdata = cd;
    #1;
    if (model_valid) begin
      check("model rdata", csr_rdata, m_expected_rdata());
      check("model mtvec", csr_mtvec, m_mtvec);
      check("model mepc", csr_mepc, m_mepc);
      check("model mstatus", csr_mstatus, m_status(m_mie_bit, m_mpie_bit));
      check("model gie", 32'(global_int_en), 32'(m_mie_bit));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle_read(input logic [11:0] ra, input logic ret);
    apply(1'b0, ret, ra, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 32'h0);
  endtask

  logic [11:0] pool [18] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                             12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14,
                             12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h123, 12'h7C0};

  initial begin
    @(posedge clk); #1;

    // Reset overrides a simultaneous mepc write
    apply(1'b1, 1'b0, 12'h341, 1'b1, 12'h341, 32'h100, 1'b0, 12'h0, 32'h0);
    advance();
    idle_read(12'h341, 1'b0);
    check("reset mepc read", csr_rdata, 32'h0);
    check("reset mstatus", csr_mstatus, 32'h0000_1800);
    check("reset mtvec", csr_mtvec, 32'h8000_0000);
    check("reset mepc", csr_mepc, 32'h0);
    advance();

    // Mask test
    apply(1'b0, 1'b0, 12'h300, 1'b1, 12'h300, 32'hFFFF_FFFF, 1'b0, 12'h0, 32'h0);
    check("mask mstatus fwd", csr_rdata, 32'h0000_1888);
    advance();
    apply(1'b0, 1'b0, 12'h300, 1'b1, 12'h305, 32'h8000_0103, 1'b0, 12'h0, 32'h0);
    check("mask mstatus reg", csr_mstatus, 32'h0000_1888);
    check("mask gie", 32'(global_int_en), 32'h1);
    advance();
    idle_read(12'h305, 1'b0);
    check("mask mtvec read", csr_rdata, 32'h8000_0100);
    check("mask mtvec reg", csr_mtvec, 32'h8000_0100);
    advance();

    // Collision: clint wins on the same address
    apply(1'b0, 1'b0, 12'h341, 1'b1, 12'h341, 32'h88, 1'b1, 12'h341, 32'h44);
    check("collide fwd", csr_rdata, 32'h44);
    check("collide no early mepc", csr_mepc, 32'h0);
    advance();
    idle_read(12'h341, 1'b0);
    check("collide mepc", csr_mepc, 32'h44);
    advance();

    // Carry test from a fresh reset
    apply(1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 32'h0);
    advance();
    apply(1'b0, 1'b0, 12'hB00, 1'b1, 12'hB00, 32'hFFFF_FFFE, 1'b0, 12'h0, 32'h0);
    check("carry fwd", csr_rdata, 32'hFFFF_FFFE);
    advance();
    idle_read(12'hB00, 1'b0);
    check("carry no inc on write", csr_rdata, 32'hFFFF_FFFE);
    advance();
    idle_read(12'hB00, 1'b0);
    check("carry lo ff", csr_rdata, 32'hFFFF_FFFF);
    advance();
    idle_read(12'hB00, 1'b0);
    check("carry lo wrap", csr_rdata, 32'h0);
    advance();
    idle_read(12'hB80, 1'b0);
    check("carry hi", csr_rdata, 32'h1);
    advance();

    // Trap sequence
    apply(1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 32'h0);
    advance();
    apply(1'b0, 1'b1, 12'h341, 1'b0, 12'h0, 32'h0, 1'b1, 12'h341, 32'h20);
    advance();
    apply(1'b0, 1'b0, 12'h341, 1'b0, 12'h0, 32'h0, 1'b1, 12'h300, 32'h80);
    check("trap mepc", csr_mepc, 32'h20);
    advance();
    apply(1'b0, 1'b1, 12'h300, 1'b0, 12'h0, 32'h0, 1'b1, 12'h342, 32'd11);
    check("trap mstatus", csr_mstatus, 32'h0000_1880);
    check("trap gie", 32'(global_int_en), 32'h0);
    advance();
    idle_read(12'h342, 1'b0);
    check("trap mcause", csr_rdata, 32'd11);
    advance();
    idle_read(12'hC02, 1'b0);
    check("trap instret", csr_rdata, 32'd2);
    check("trap hartid alias path", 32'(csr_raddr == 12'hC02), 32'h1);
    advance();
    idle_read(12'hF14, 1'b0);
    check("hartid", csr_rdata, TB_HART_ID);
    advance();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic        r, ret, ewe, cwe;
      logic [11:0] ra, ea, ca;
      logic [31:0] ed, cd;
      r   = ($urandom_range(0, 39) == 0);
      ret = ($urandom_range(0, 1) == 1);
      ewe = ($urandom_range(0, 1) == 1);
      cwe = ($urandom_range(0, 2) == 0);
      ea  = pool[$urandom_range(0, 17)];
      ca  = ($urandom_range(0, 3) == 0) ? ea : pool[$urandom_range(0, 17)];
      ra  = ($urandom_range(0, 2) == 0) ? ea : pool[$urandom_range(0, 17)];
      ed  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      cd  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom);
      apply(r, ret, ra, ewe, ea, ed, cwe, ca, cd);
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/csr_regfile.md
CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 SHALL provide parameter MTVEC_RST, default 32'h0000_0000: mtvec reset value (bits [1:0] ignored).
REQ-002 SHALL provide parameter HART_ID, default 32'h0: value returned by mhartid.
REQ-003 SHALL have ports, in this order (name, direction, width, meaning):
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- inst_retired  input  1  one instruction retired this cycle.
- csr_raddr  input  12  pipeline read address.
- csr_rdata  output  32  pipeline read data.
- ex_csr_we  input  1  pipeline (Zicsr instruction) write enable.
- ex_csr_waddr  input  12  pipeline write address.
- ex_csr_wdata  input  32  pipeline write data.
- clint_csr_we  input  1  trap controller write enable.
- clint_csr_waddr  input  12  trap controller write address.
- clint_csr_wdata  input  32  trap controller write data.
- csr_mtvec  output  32  registered mtvec.
- csr_mepc  output  32  registered mepc.
- csr_mstatus  output  32  registered mstatus.
- global_int_en  output  1  mstatus.MIE.

Function
REQ-004 SHALL implement mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82, mhartid 0xF14.
REQ-005 SHALL implement cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82 as read-only aliases; writes to them SHALL be ignored.
REQ-006 Unimplemented addresses SHALL read 32'h0; writes to them SHALL be ignored.
REQ-007 Writes SHALL commit at the rising clk edge; reads SHALL be combinational.
REQ-008 When both write ports are enabled in one cycle, the clint port SHALL win:
- same address: ex write discarded;
- different addresses: both commit.
REQ-009 csr_rdata SHALL forward the data that will commit this cycle when csr_raddr matches an active write address, after masking (REQ-010..012), with clint-over-ex priority.
REQ-010 mstatus writable bits SHALL be MIE[3] and MPIE[7] only; MPP[12:11] SHALL read 2'b11; all other bits SHALL read 0.
REQ-011 mtvec[1:0] and mepc[1:0] SHALL be forced to 0 on write (direct mode, aligned).
REQ-012 mip SHALL read 0; mhartid SHALL read HART_ID. Writes to either SHALL be ignored.
REQ-013 mcycle SHALL increment by 1 every cycle out of reset, as a 64-bit counter wrapping from all-ones to 0.
REQ-014 minstret SHALL increment by 1 in cycles where inst_retired=1, as a 64-bit counter that wraps.
REQ-015 A write to a counter half SHALL replace that 32-bit half, leave the other half unchanged, and suppress the increment for that cycle.
REQ-016 A low-half increment carry SHALL propagate to the high half in the same edge, e.g. 32'hFFFF_FFFF -> 0 with high +1.
REQ-017 csr_mtvec, csr_mepc, csr_mstatus and global_int_en SHALL reflect register contents only, with no forwarding; new values SHALL be visible the cycle after the write.

Reset
REQ-018 When rst=1 at a clock edge, the following SHALL apply:
- mtvec <= {MTVEC_RST[31:2],2'b00};
- mstatus <= 32'h0000_1800;
- all other registers and counters <= 0.
REQ-019 Reset SHALL override any simultaneous write or increment.
REQ-020 Outputs SHALL equal the reset register values in the cycle after reset.

Structure
REQ-021 CSR addresses and the mstatus bit positions (MIE=3, MPIE=7) SHALL be defined in defines.v, alongside the existing CSR_MEPC, CSR_MSTATUS and CSR_MCAUSE.
REQ-022 SHALL instantiate sub-module csr_counter64 twice, for mcycle and minstret. csr_counter64 SHALL provide:
- inc enable;
- lo/hi write enables;
- wdata;
- 64-bit value.

Verification
REQ-023 Reset test: write mepc=32'h100 with rst=1 -> mepc reads 0, mstatus reads 32'h1800, mtvec reads MTVEC_RST with [1:0]=0.
REQ-024 Collision test: clint writes mepc=32'h0000_0044 and ex writes mepc=32'h0000_0088 in the same cycle.
- Required: csr_rdata at 0x341 forwards 32'h44 that cycle.
- Required: csr_mepc=32'h44 the next cycle.
REQ-025 Mask test: ex writes mstatus=32'hFFFF_FFFF -> reads 32'h0000_1888 and global_int_en=1. Ex writes mtvec=32'h8000_0103 -> reads 32'h8000_0100.
REQ-026 Carry test: preset mcycle lo=32'hFFFF_FFFE via ex, then let 2 cycles pass.
- Required: mcycleh=1 and mcycle=0.
- Required: the cycle of the write shows no increment.
REQ-027 Trap sequence test: clint writes mepc=32'h20, mstatus with MIE=0, then mcause=32'd11 on consecutive cycles.
- Required: each value visible the following cycle.
- Required: minstret counts only cycles with inst_retired=1.
